sys_ctrl_axil_regs: RTL and testbench

AXI-Lite responder implementing the system control register file in the 4 KiB window at 0x0000_2000–0x0000_2FFF, attached as port 0 of the peripheral link. It accepts AXI-Lite requests from the link and drives the static control outputs. Those outputs are per-domain clock-enable and soft-reset bits, core boot addresses, boot hart IDs, and PLL configuration words, consumed by the clock/reset and core subsystems.

---
 rtl/sys_ctrl_axil_regs.sv | 354 +++++++++++++++++++++++++++++++++++
 tb/tb_sys_ctrl_axil_regs.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_axil_regs.sv
// sys_ctrl_axil_regs: system control register file on the peripheral link.
// AXI-Lite responder driving clock/reset, boot and PLL control outputs.
package sys_ctrl_axil_pkg;

   typedef struct packed {
      logic [31:0] aw_addr;
      logic [2:0]  aw_prot;
      logic        aw_valid;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      logic        w_valid;
      logic        b_ready;
      logic [31:0] ar_addr;
      logic [2:0]  ar_prot;
      logic        ar_valid;
      logic        r_ready;
   } pl_sc_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic [1:0]  b_resp;
      logic        b_valid;
      logic        ar_ready;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_valid;
   } pl_sc_resp_t;

   typedef pl_sc_req_t  req_t;
   typedef pl_sc_resp_t resp_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [9:0] IDX_E_CORE    = 10'h000;
   localparam logic [9:0] IDX_P_CORE    = 10'h001;
   localparam logic [9:0] IDX_CORE_LINK = 10'h002;
   localparam logic [9:0] IDX_SYS_LINK  = 10'h003;
   localparam logic [9:0] IDX_PERIPH    = 10'h004;
   localparam logic [9:0] IDX_BOOT_E    = 10'h010;
   localparam logic [9:0] IDX_BOOT_P    = 10'h011;
   localparam logic [9:0] IDX_HART_E    = 10'h020;
   localparam logic [9:0] IDX_HART_P    = 10'h021;
   localparam logic [9:0] IDX_PLL_E     = 10'h030;
   localparam logic [9:0] IDX_PLL_P     = 10'h031;
   localparam logic [9:0] IDX_PLL_SYS   = 10'h033;

endpackage

module sys_ctrl_axil_regs
   import sys_ctrl_axil_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR_E_RST = 32'h0900_0000,
   parameter logic [31:0] BOOT_ADDR_P_RST = 32'h0900_0000,
   parameter logic [31:0] PLL_CFG_RST     = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        arst_ni,
   input  req_t        req_i,
   output resp_t       resp_o,
   output logic        e_core_clk_en_o,
   output logic        e_core_rst_no,
   output logic        p_core_clk_en_o,
   output logic        p_core_rst_no,
   output logic        core_link_clk_en_o,
   output logic        core_link_rst_no,
   output logic        sys_link_clk_en_o,
   output logic        sys_link_rst_no,
   output logic        periph_link_clk_en_o,
   output logic        periph_link_rst_no,
   output logic [31:0] boot_addr_e_core_o,
   output logic [31:0] boot_addr_p_core_o,
   output logic [31:0] boot_hartid_e_core_o,
   output logic [31:0] boot_hartid_p_core_o,
   output logic [31:0] pll_cfg_e_core_o,
   output logic [31:0] pll_cfg_p_core_o,
   output logic [31:0] pll_cfg_sys_link_o
);

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_e;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] data,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic is_mapped(input logic [9:0] idx);
      logic hit;
      hit = 1'b0;
      unique case (idx)
         IDX_E_CORE, IDX_P_CORE, IDX_CORE_LINK,
         IDX_SYS_LINK, IDX_PERIPH,
         IDX_BOOT_E, IDX_BOOT_P,
         IDX_HART_E, IDX_HART_P,
         IDX_PLL_E, IDX_PLL_P, IDX_PLL_SYS: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   // register state
   logic [1:0]  e_core_q;
   logic [1:0]  p_core_q;
   logic [1:0]  core_link_q;
   logic [1:0]  sys_link_q;
   logic [31:0] boot_addr_e_q;
   logic [31:0] boot_addr_p_q;
   logic [31:0] hartid_e_q;
   logic [31:0] hartid_p_q;
   logic [31:0] pll_e_q;
   logic [31:0] pll_p_q;
   logic [31:0] pll_sys_q;

   // write channel state
   w_state_e    w_state;
   logic        aw_ready_q;
   logic        w_ready_q;
   logic        b_valid_q;
   logic [1:0]  b_resp_q;
   logic [9:0]  aw_idx_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;

   // read channel state
   r_state_e    r_state;
   logic        ar_ready_q;
   logic        r_valid_q;
   logic [1:0]  r_resp_q;
   logic [31:0] r_data_q;

   logic        aw_hs;
   logic        w_hs;
   logic        wr_fire;
   logic [9:0]  wr_idx;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_hit;
   logic [9:0]  rd_idx;
   logic [31:0] rd_data;
   logic        rd_hit;

   logic        unused_bits;

   assign unused_bits = ^{req_i.aw_addr[31:12], req_i.aw_addr[1:0],
                          req_i.ar_addr[31:12], req_i.ar_addr[1:0],
                          req_i.aw_prot, req_i.ar_prot};

   assign aw_hs = req_i.aw_valid & aw_ready_q;
   assign w_hs  = req_i.w_valid & w_ready_q;

   // merge the live handshake with whatever half was latched earlier
   always_comb begin
      wr_idx  = aw_hs ? req_i.aw_addr[11:2] : aw_idx_q;
      wr_data = w_hs ? req_i.w_data : w_data_q;
      wr_strb = w_hs ? req_i.w_strb : w_strb_q;
      wr_fire = (aw_hs | (w_state == W_HAVE_AW))
              & (w_hs | (w_state == W_HAVE_W));
      wr_hit  = is_mapped(wr_idx);
   end

   // write channel FSM: collect AW and W in any order, then respond
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         w_state    <= W_IDLE;
         aw_ready_q <= 1'b1;
         w_ready_q  <= 1'b1;
         b_valid_q  <= 1'b0;
         b_resp_q   <= RESP_OKAY;
         aw_idx_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
      end else begin
         unique case (w_state)
            W_IDLE, W_HAVE_AW, W_HAVE_W: begin
               if (aw_hs) aw_idx_q <= req_i.aw_addr[11:2];
               if (w_hs) begin
                  w_data_q <= req_i.w_data;
                  w_strb_q <= req_i.w_strb;
               end
               if (wr_fire) begin
                  w_state    <= W_RESP;
                  aw_ready_q <= 1'b0;
                  w_ready_q  <= 1'b0;
                  b_valid_q  <= 1'b1;
                  b_resp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
               end else if (aw_hs) begin
                  w_state    <= W_HAVE_AW;
                  aw_ready_q <= 1'b0;
               end else if (w_hs) begin
                  w_state   <= W_HAVE_W;
                  w_ready_q <= 1'b0;
               end
            end
            W_RESP: begin
               if (req_i.b_ready) begin
                  w_state    <= W_IDLE;
                  aw_ready_q <= 1'b1;
                  w_ready_q  <= 1'b1;
                  b_valid_q  <= 1'b0;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // register file update on a committed write
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         e_core_q      <= 2'b11;
         p_core_q      <= 2'b00;
         core_link_q   <= 2'b11;
         sys_link_q    <= 2'b11;
         boot_addr_e_q <= BOOT_ADDR_E_RST;
         boot_addr_p_q <= BOOT_ADDR_P_RST;
         hartid_e_q    <= 32'd0;
         hartid_p_q    <= 32'd1;
         pll_e_q       <= PLL_CFG_RST;
         pll_p_q       <= PLL_CFG_RST;
         pll_sys_q     <= PLL_CFG_RST;
      end else if (wr_fire) begin
         unique case (wr_idx)
            IDX_E_CORE:
               if (wr_strb[0]) e_core_q <= wr_data[1:0];
            IDX_P_CORE:
               if (wr_strb[0]) p_core_q <= wr_data[1:0];
            IDX_CORE_LINK:
               if (wr_strb[0]) core_link_q <= wr_data[1:0];
            IDX_SYS_LINK:
               if (wr_strb[0]) sys_link_q <= wr_data[1:0];
            IDX_BOOT_E:
               boot_addr_e_q <= merge(boot_addr_e_q, wr_data, wr_strb);
            IDX_BOOT_P:
               boot_addr_p_q <= merge(boot_addr_p_q, wr_data, wr_strb);
            IDX_HART_E:
               hartid_e_q <= merge(hartid_e_q, wr_data, wr_strb);
            IDX_HART_P:
               hartid_p_q <= merge(hartid_p_q, wr_data, wr_strb);
            IDX_PLL_E:
               pll_e_q <= merge(pll_e_q, wr_data, wr_strb);
            IDX_PLL_P:
               pll_p_q <= merge(pll_p_q, wr_data, wr_strb);
            IDX_PLL_SYS:
               pll_sys_q <= merge(pll_sys_q, wr_data, wr_strb);
            default: ;
         endcase
      end
   end

   assign rd_idx = req_i.ar_addr[11:2];

   // read mux over current register state; periph link reads fixed 1s
   always_comb begin
      rd_data = 32'd0;
      rd_hit  = 1'b1;
      unique case (rd_idx)
         IDX_E_CORE:    rd_data = {30'd0, e_core_q};
         IDX_P_CORE:    rd_data = {30'd0, p_core_q};
         IDX_CORE_LINK: rd_data = {30'd0, core_link_q};
         IDX_SYS_LINK:  rd_data = {30'd0, sys_link_q};
         IDX_PERIPH:    rd_data = 32'd3;
         IDX_BOOT_E:    rd_data = boot_addr_e_q;
         IDX_BOOT_P:    rd_data = boot_addr_p_q;
         IDX_HART_E:    rd_data = hartid_e_q;
         IDX_HART_P:    rd_data = hartid_p_q;
         IDX_PLL_E:     rd_data = pll_e_q;
         IDX_PLL_P:     rd_data = pll_p_q;
         IDX_PLL_SYS:   rd_data = pll_sys_q;
         default: begin
            rd_data = 32'd0;
            rd_hit  = 1'b0;
         end
      endcase
   end

   // read channel FSM: capture on AR, hold response until R handshake
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state    <= R_IDLE;
         ar_ready_q <= 1'b1;
         r_valid_q  <= 1'b0;
         r_resp_q   <= RESP_OKAY;
         r_data_q   <= 32'd0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               if (req_i.ar_valid) begin
                  r_state    <= R_RESP;
                  ar_ready_q <= 1'b0;
                  r_valid_q  <= 1'b1;
                  r_data_q   <= rd_data;
                  r_resp_q   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_RESP: begin
               if (req_i.r_ready) begin
                  r_state    <= R_IDLE;
                  ar_ready_q <= 1'b1;
                  r_valid_q  <= 1'b0;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign resp_o.aw_ready = aw_ready_q;
   assign resp_o.w_ready  = w_ready_q;
   assign resp_o.b_resp   = b_resp_q;
   assign resp_o.b_valid  = b_valid_q;
   assign resp_o.ar_ready = ar_ready_q;
   assign resp_o.r_data   = r_data_q;
   assign resp_o.r_resp   = r_resp_q;
   assign resp_o.r_valid  = r_valid_q;

   assign e_core_clk_en_o      = e_core_q[0];
   assign e_core_rst_no        = e_core_q[1];
   assign p_core_clk_en_o      = p_core_q[0];
   assign p_core_rst_no        = p_core_q[1];
   assign core_link_clk_en_o   = core_link_q[0];
   assign core_link_rst_no     = core_link_q[1];
   assign sys_link_clk_en_o    = sys_link_q[0];
   assign sys_link_rst_no      = sys_link_q[1];
   assign periph_link_clk_en_o = 1'b1;
   assign periph_link_rst_no   = 1'b1;

   assign boot_addr_e_core_o   = boot_addr_e_q;
   assign boot_addr_p_core_o   = boot_addr_p_q;
   assign boot_hartid_e_core_o = hartid_e_q;
   assign boot_hartid_p_core_o = hartid_p_q;
   assign pll_cfg_e_core_o     = pll_e_q;
   assign pll_cfg_p_core_o     = pll_p_q;
   assign pll_cfg_sys_link_o   = pll_sys_q;

endmodule

// File: tb/tb_sys_ctrl_axil_regs.sv
// tb_sys_ctrl_axil_regs: directed bench for the system control registers.
// Reference model and response queues supply every expected value.
module tb_sys_ctrl_axil_regs;
   import sys_ctrl_axil_pkg::*;

   logic        clk;
   logic        arst_ni;
   req_t        req;
   resp_t       resp;
   logic        e_clk, e_rst, p_clk, p_rst;
   logic        cl_clk, cl_rst, sl_clk, sl_rst, pl_clk, pl_rst;
   logic [31:0] boot_e, boot_p, hart_e, hart_p;
   logic [31:0] pll_e, pll_p, pll_sys;

   int passed = 0;
   int total  = 0;

   logic [31:0] mreg [int];
   logic [33:0] rq [$];
   logic [1:0]  bq [$];

   sys_ctrl_axil_regs dut (
      .clk_i                (clk),
      .arst_ni              (arst_ni),
      .req_i                (req),
      .resp_o               (resp),
      .e_core_clk_en_o      (e_clk),
      .e_core_rst_no        (e_rst),
      .p_core_clk_en_o      (p_clk),
      .p_core_rst_no        (p_rst),
      .core_link_clk_en_o   (cl_clk),
      .core_link_rst_no     (cl_rst),
      .sys_link_clk_en_o    (sl_clk),
      .sys_link_rst_no      (sl_rst),
      .periph_link_clk_en_o (pl_clk),
      .periph_link_rst_no   (pl_rst),
      .boot_addr_e_core_o   (boot_e),
      .boot_addr_p_core_o   (boot_p),
      .boot_hartid_e_core_o (hart_e),
      .boot_hartid_p_core_o (hart_p),
      .pll_cfg_e_core_o     (pll_e),
      .pll_cfg_p_core_o     (pll_p),
      .pll_cfg_sys_link_o   (pll_sys)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic void m_reset();
      mreg.delete();
      mreg[32'h000] = 32'h3;
      mreg[32'h004] = 32'h0;
      mreg[32'h008] = 32'h3;
      mreg[32'h00C] = 32'h3;
      mreg[32'h010] = 32'h3;
      mreg[32'h040] = 32'h0900_0000;
      mreg[32'h044] = 32'h0900_0000;
      mreg[32'h080] = 32'h0;
      mreg[32'h084] = 32'h1;
      mreg[32'h0C0] = 32'h0;
      mreg[32'h0C4] = 32'h0;
      mreg[32'h0CC] = 32'h0;
   endfunction

   function automatic logic [33:0] m_read(input logic [31:0] a);
      int o;
      o = int'({20'd0, a[11:2], 2'b00});
      if (mreg.exists(o)) return {2'b00, mreg[o]};
      return {2'b10, 32'd0};
   endfunction

   function automatic logic [1:0] m_write(input logic [31:0] a,
                                          input logic [31:0] d,
                                          input logic [3:0]  s);
      int o;
      logic [31:0] t;
      o = int'({20'd0, a[11:2], 2'b00});
      if (!mreg.exists(o)) return 2'b10;
      if (o <= 32'h00C) begin
         if (s[0]) mreg[o] = {30'd0, d[1:0]};
      end else if (o != 32'h010) begin
         t = mreg[o];
         for (int b = 0; b < 4; b++)
            if (s[b]) t[8*b +: 8] = d[8*b +: 8];
         mreg[o] = t;
      end
      return 2'b00;
   endfunction

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      int n;
      logic aw_h, w_h;
      bit aw_done, w_done;
      n = 0;
      aw_done = 0;
      w_done = 0;
      bq.push_back(m_write(a, d, s));
      req.aw_addr = a;
      req.aw_valid = 1'b1;
      req.w_data = d;
      req.w_strb = s;
      req.w_valid = 1'b1;
      req.b_ready = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_h = req.aw_valid & resp.aw_ready;
         w_h  = req.w_valid & resp.w_ready;
         @(posedge clk); #1;
         n++;
         if (aw_h) begin aw_done = 1; req.aw_valid = 1'b0; end
         if (w_h) begin w_done = 1; req.w_valid = 1'b0; end
      end
      req.aw_valid = 1'b0;
      req.w_valid = 1'b0;
      chk($sformatf("wr_bvalid_%h", a), {31'd0, resp.b_valid}, 32'd1);
      chk($sformatf("wr_bresp_%h", a), {30'd0, resp.b_resp},
          {30'd0, bq.pop_front()});
      @(posedge clk); #1;
      req.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [33:0] e);
      int n;
      logic [33:0] x;
      n = 0;
      rq.push_back(e);
      req.ar_addr = a;
      req.ar_valid = 1'b1;
      req.r_ready = 1'b1;
      while (!resp.ar_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      req.ar_valid = 1'b0;
      chk($sformatf("rd_rvalid_%h", a), {31'd0, resp.r_valid}, 32'd1);
      x = rq.pop_front();
      chk($sformatf("rd_data_%h", a), resp.r_data, x[31:0]);
      chk($sformatf("rd_resp_%h", a), {30'd0, resp.r_resp},
          {30'd0, x[33:32]});
      @(posedge clk); #1;
      req.r_ready = 1'b0;
      chk($sformatf("rd_arready_back_%h", a),
          {31'd0, resp.ar_ready}, 32'd1);
   endtask

   logic [31:0] offs [12];
   logic [33:0] pre;
   logic [1:0]  bexp;

   initial begin
      offs = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h040,
               32'h044, 32'h080, 32'h084, 32'h0C0, 32'h0C4, 32'h0CC};
      arst_ni = 1'b0;
      req = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_e_rst_n", {31'd0, e_rst}, 32'd1);
      chk("rst_p_clk_en", {31'd0, p_clk}, 32'd0);
      chk("rst_boot_e", boot_e, 32'h0900_0000);
      chk("rst_boot_p", boot_p, 32'h0900_0000);
      chk("rst_awready", {31'd0, resp.aw_ready}, 32'd1);
      chk("rst_wready", {31'd0, resp.w_ready}, 32'd1);
      chk("rst_arready", {31'd0, resp.ar_ready}, 32'd1);
      chk("rst_bvalid", {31'd0, resp.b_valid}, 32'd0);
      chk("rst_rvalid", {31'd0, resp.r_valid}, 32'd0);
      chk("rst_rdata", resp.r_data, 32'd0);
      @(negedge clk);
      arst_ni = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) axi_read(offs[i], m_read(offs[i]));

      // same-cycle AW/W with partial strobes
      bq.push_back(m_write(32'h044, 32'hDEAD_BEEF, 4'b0101));
      req.aw_addr = 32'h044;
      req.w_data = 32'hDEAD_BEEF;
      req.w_strb = 4'b0101;
      req.aw_valid = 1'b1;
      req.w_valid = 1'b1;
      req.b_ready = 1'b0;
      chk("strb_pre_boot_p", boot_p, 32'h0900_0000);
      @(posedge clk); #1;
      req.aw_valid = 1'b0;
      req.w_valid = 1'b0;
      chk("strb_boot_p", boot_p, 32'h09AD_00EF);
      chk("strb_bvalid", {31'd0, resp.b_valid}, 32'd1);
      chk("strb_bresp", {30'd0, resp.b_resp}, {30'd0, bq.pop_front()});
      req.b_ready = 1'b1;
      @(posedge clk); #1;
      req.b_ready = 1'b0;
      chk("strb_bvalid_drop", {31'd0, resp.b_valid}, 32'd0);
      axi_read(32'h044, m_read(32'h044));
      axi_read(32'hFFFF_F044, m_read(32'hFFFF_F044));

      // W ahead of AW, B held off
      bq.push_back(m_write(32'h0C4, 32'hCAFE_F00D, 4'hF));
      req.w_data = 32'hCAFE_F00D;
      req.w_strb = 4'hF;
      req.w_valid = 1'b1;
      @(posedge clk); #1;
      req.w_valid = 1'b0;
      chk("wfirst_wready", {31'd0, resp.w_ready}, 32'd0);
      chk("wfirst_awready", {31'd0, resp.aw_ready}, 32'd1);
      chk("wfirst_bvalid", {31'd0, resp.b_valid}, 32'd0);
      chk("wfirst_pll_p_hold", pll_p, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      req.aw_addr = 32'h0C4;
      req.aw_valid = 1'b1;
      @(posedge clk); #1;
      chk("wfirst_pll_p", pll_p, 32'hCAFE_F00D);
      req.aw_addr = 32'h080;
      bexp = bq.pop_front();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bhold_bvalid_%0d", i), {31'd0, resp.b_valid}, 32'd1);
         chk($sformatf("bhold_bresp_%0d", i), {30'd0, resp.b_resp},
             {30'd0, bexp});
         chk($sformatf("bhold_awready_%0d", i),
             {31'd0, resp.aw_ready}, 32'd0);
         @(posedge clk); #1;
      end
      req.aw_valid = 1'b0;
      req.b_ready = 1'b1;
      @(posedge clk); #1;
      req.b_ready = 1'b0;
      chk("bhold_done", {31'd0, resp.b_valid}, 32'd0);
      axi_read(32'h0C4, m_read(32'h0C4));
      axi_read(32'h080, m_read(32'h080));

      // clock/reset control registers
      axi_write(32'h010, 32'h0, 4'hF);
      axi_read(32'h010, m_read(32'h010));
      chk("periph_clk_en", {31'd0, pl_clk}, 32'd1);
      chk("periph_rst_n", {31'd0, pl_rst}, 32'd1);
      axi_write(32'h004, 32'h3, 4'hF);
      chk("p_clk_en_up", {31'd0, p_clk}, 32'd1);
      chk("p_rst_n_up", {31'd0, p_rst}, 32'd1);
      axi_write(32'h000, 32'h0, 4'b1110);
      chk("e_clk_nostrb", {31'd0, e_clk}, 32'd1);
      axi_write(32'h008, 32'hFFFF_FFFE, 4'hF);
      chk("cl_clk_off", {31'd0, cl_clk}, 32'd0);
      axi_read(32'h008, m_read(32'h008));

      // unmapped offsets
      axi_write(32'h0C8, 32'h1111_1111, 4'hF);
      axi_write(32'h800, 32'h2222_2222, 4'hF);
      axi_read(32'h0C8, m_read(32'h0C8));
      axi_read(32'h800, m_read(32'h800));
      axi_read(32'h0CC, m_read(32'h0CC));

      // same-cycle read and write of one register
      pre = m_read(32'h080);
      fork
         axi_write(32'h080, 32'h0000_0005, 4'hF);
         axi_read(32'h080, pre);
      join
      chk("rw_hart_e", hart_e, 32'h5);
      axi_read(32'h080, m_read(32'h080));

      // reset while a read response is pending
      axi_write(32'h0C0, 32'h0000_1234, 4'hF);
      rq.push_back(m_read(32'h0C0));
      req.ar_addr = 32'h0C0;
      req.ar_valid = 1'b1;
      req.r_ready = 1'b0;
      @(posedge clk); #1;
      req.ar_valid = 1'b0;
      chk("mid_rvalid", {31'd0, resp.r_valid}, 32'd1);
      chk("mid_pll_e", pll_e, 32'h1234);
      #2;
      arst_ni = 1'b0;
      #1;
      chk("arst_rvalid", {31'd0, resp.r_valid}, 32'd0);
      chk("arst_pll_e", pll_e, 32'd0);
      chk("arst_p_clk", {31'd0, p_clk}, 32'd0);
      chk("arst_arready", {31'd0, resp.ar_ready}, 32'd1);
      rq.delete();
      bq.delete();
      m_reset();
      @(negedge clk);
      arst_ni = 1'b1;
      @(posedge clk); #1;
      axi_read(32'h0C0, m_read(32'h0C0));
      axi_read(32'h004, m_read(32'h004));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
